// File: rtl/therm2sc_pkg.sv
// Shared state encoding and width helpers for the multi-channel serial
// thermometer to two's-complement converter.
package therm2sc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    // Magnitude width: must hold THERM_LEN itself (all beats ones).
    function automatic int mag_width(input int therm_len);
        return $clog2(therm_len + 1);
    endfunction

    // Signed per-channel width: magnitude plus a sign bit.
    function automatic int res_width(input int therm_len);
        return mag_width(therm_len) + 1;
    endfunction

    // Sum width: growth of one bit per doubling of channel count.
    function automatic int sum_width(input int therm_len, input int num_ch);
        return res_width(therm_len) + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/therm_serial_to_2scomp_multi_channel.sv
// One serial channel: sign latch, ones counter, bubble tracking and the
// signed value, exposed as a look-ahead that includes the beat in flight.
module therm_channel_counter
    import therm2sc_pkg::*;
#(
    parameter int MAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             beat,
    input  logic             bit_in,
    output logic             sign,
    output logic [MAG_W-1:0] mag_nxt,
    output logic             bubble_nxt,
    output logic [MAG_W:0]   value_nxt
);

    logic [MAG_W-1:0] mag;
    logic             bubble;
    logic             seen_zero;

    // Apply the sign to the magnitude; a zero magnitude stays zero either way.
    function automatic logic signed [MAG_W:0] sign_apply(input logic s,
                                                         input logic [MAG_W-1:0] m);
        logic signed [MAG_W:0] m_s;
        m_s = {1'b0, m};
        return s ? -m_s : m_s;
    endfunction

    // Sign beat reloads the channel; each magnitude beat counts ones and notes 0->1 steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign      <= 1'b0;
            mag       <= '0;
            bubble    <= 1'b0;
            seen_zero <= 1'b0;
        end else if (load) begin
            sign      <= bit_in;
            mag       <= '0;
            bubble    <= 1'b0;
            seen_zero <= 1'b0;
        end else if (beat) begin
            mag    <= mag_nxt;
            bubble <= bubble_nxt;
            if (!bit_in) seen_zero <= 1'b1;
        end
    end

    // Look-ahead so the top can register the final result on the last beat itself.
    always_comb begin
        mag_nxt    = mag;
        bubble_nxt = bubble;
        if (beat) begin
            mag_nxt    = mag + MAG_W'(bit_in);
            bubble_nxt = bubble | (bit_in & seen_zero);
        end
        value_nxt = sign_apply(sign, mag_nxt);
    end

endmodule

// File: rtl/therm_serial_to_2scomp_multi.sv
// Multi-channel serial thermometer to two's-complement converter: frame
// sequencing, beat counting, cross-channel sum and held output registers.
module therm_serial_to_2scomp_multi
    import therm2sc_pkg::*;
#(
    parameter int THERM_LEN = 32,
    parameter int NUM_CH    = 4,
    parameter int OUT_MODE  = 1,
    localparam int MAG_W = mag_width(THERM_LEN),
    localparam int RES_W = res_width(THERM_LEN),
    localparam int SUM_W = sum_width(THERM_LEN, NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    serial_valid,
    input  logic [NUM_CH-1:0]       serial_in,
    input  logic                    abort,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*RES_W-1:0] result_out,
    output logic [NUM_CH*MAG_W-1:0] mag_out,
    output logic [SUM_W-1:0]        sum_out,
    output logic [NUM_CH-1:0]       bubble_err
);

    state_t     state;
    logic [MAG_W-1:0] beat_cnt;

    logic accept_sign;
    logic beat;
    logic last_beat;

    logic [NUM_CH-1:0]       ch_sign;
    logic [NUM_CH-1:0]       ch_bubble;
    logic [MAG_W-1:0]        ch_mag [NUM_CH];
    logic signed [RES_W-1:0] ch_val [NUM_CH];

    logic signed [SUM_W-1:0]  sum_nxt;
    logic [NUM_CH*RES_W-1:0]  res_nxt;
    logic [NUM_CH*MAG_W-1:0]  mag_pack;

    // Handshake qualifiers; abort overrides any sign or magnitude beat.
    always_comb begin
        accept_sign = !abort && start && serial_valid &&
                      ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
        beat        = !abort && serial_valid && (state == ST_SHIFT);
        last_beat   = beat && (beat_cnt == MAG_W'(THERM_LEN - 1));
    end

    assign busy      = (state == ST_SHIFT);
    assign out_valid = (state == ST_HOLD);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [MAG_W:0] val_raw;

        therm_channel_counter #(
            .MAG_W (MAG_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .load       (accept_sign),
            .beat       (beat),
            .bit_in     (serial_in[i]),
            .sign       (ch_sign[i]),
            .mag_nxt    (ch_mag[i]),
            .bubble_nxt (ch_bubble[i]),
            .value_nxt  (val_raw)
        );

        assign ch_val[i] = val_raw;
    end

    // Adder tree and output packing; sum always uses signed values regardless of OUT_MODE.
    always_comb begin
        sum_nxt  = '0;
        res_nxt  = '0;
        mag_pack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_nxt = sum_nxt + SUM_W'(ch_val[i]);
            mag_pack[i*MAG_W +: MAG_W] = ch_mag[i];
            if (OUT_MODE != 0) res_nxt[i*RES_W +: RES_W] = ch_val[i];
            else               res_nxt[i*RES_W +: RES_W] = {ch_sign[i], ch_mag[i]};
        end
    end

    // Frame sequencing: IDLE -> SHIFT on sign beat, SHIFT -> HOLD on last beat, HOLD exits on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
        end else if (accept_sign) begin
            state    <= ST_SHIFT;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_SHIFT: if (beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (last_beat) state <= ST_HOLD;
                end
                ST_HOLD:  if (out_ready) state <= ST_IDLE;
                ST_IDLE:  ;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Result registers load only on the last beat and otherwise hold, including across abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_out <= '0;
            mag_out    <= '0;
            sum_out    <= '0;
            bubble_err <= '0;
        end else if (last_beat) begin
            result_out <= res_nxt;
            mag_out    <= mag_pack;
            sum_out    <= sum_nxt;
            bubble_err <= ch_bubble;
        end
    end

endmodule

// File: tb/tb_therm_serial_to_2scomp_multi.sv
// Randomised bench for therm_serial_to_2scomp_multi with a frame-level reference model.
module tb_therm_serial_to_2scomp_multi;

    localparam int L     = 32;
    localparam int N     = 4;
    localparam int MAG_W = $clog2(L + 1);
    localparam int RES_W = MAG_W + 1;
    localparam int SUM_W = RES_W + $clog2(N);

    logic clk = 1'b0;
    logic rst, start, serial_valid, abort, out_ready;
    logic [N-1:0] serial_in;

    logic busy, out_valid, busy0, out_valid0;
    logic [N*RES_W-1:0] result_out, result_out0;
    logic [N*MAG_W-1:0] mag_out, mag_out0;
    logic [SUM_W-1:0]   sum_out, sum_out0;
    logic [N-1:0]       bubble_err, bubble_err0;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] cur_sign;
    logic [N-1:0] beat_bits [L];
    logic [N-1:0] exp_sgn;
    logic [N-1:0] exp_bub;
    int exp_mag [N];
    int exp_val [N];
    int exp_sum;

    always #5 clk = ~clk;

    therm_serial_to_2scomp_multi #(.THERM_LEN(L), .NUM_CH(N), .OUT_MODE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .serial_valid(serial_valid),
        .serial_in(serial_in), .abort(abort), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .result_out(result_out), .mag_out(mag_out),
        .sum_out(sum_out), .bubble_err(bubble_err)
    );

    therm_serial_to_2scomp_multi #(.THERM_LEN(L), .NUM_CH(N), .OUT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .serial_valid(serial_valid),
        .serial_in(serial_in), .abort(abort), .busy(busy0), .out_valid(out_valid0),
        .out_ready(out_ready), .result_out(result_out0), .mag_out(mag_out0),
        .sum_out(sum_out0), .bubble_err(bubble_err0)
    );

    // Reference: count ones; bubble when the ones are not packed at the front.
    task automatic compute_expected();
        exp_sum = 0;
        exp_bub = '0;
        exp_sgn = cur_sign;
        for (int ch = 0; ch < N; ch++) begin
            int m = 0;
            for (int k = 0; k < L; k++) m += int'(beat_bits[k][ch]);
            for (int k = 0; k < m; k++) if (!beat_bits[k][ch]) exp_bub[ch] = 1'b1;
            exp_mag[ch] = m;
            exp_val[ch] = cur_sign[ch] ? -m : m;
            exp_sum += exp_val[ch];
        end
    endtask

    task automatic set_therm(input int ch, input int n);
        for (int k = 0; k < L; k++) beat_bits[k][ch] = (k < n);
    endtask

    task automatic gen_frame(input bit therm_only);
        cur_sign = N'($urandom);
        for (int ch = 0; ch < N; ch++) begin
            int m = $urandom_range(0, L);
            for (int k = 0; k < L; k++)
                beat_bits[k][ch] = therm_only ? (k < m) : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_outputs(input string name);
        for (int ch = 0; ch < N; ch++) begin
            checks++;
            if (mag_out[ch*MAG_W +: MAG_W] !== MAG_W'(exp_mag[ch]) ||
                mag_out0[ch*MAG_W +: MAG_W] !== MAG_W'(exp_mag[ch])) begin
                errors++;
                $display("FAIL %s mag ch%0d: got %0d/%0d expected %0d", name, ch,
                         mag_out[ch*MAG_W +: MAG_W], mag_out0[ch*MAG_W +: MAG_W], exp_mag[ch]);
            end
            checks++;
            if (result_out[ch*RES_W +: RES_W] !== RES_W'(exp_val[ch])) begin
                errors++;
                $display("FAIL %s result ch%0d: got %h expected %h", name, ch,
                         result_out[ch*RES_W +: RES_W], RES_W'(exp_val[ch]));
            end
            checks++;
            if (result_out0[ch*RES_W +: RES_W] !== {exp_sgn[ch], MAG_W'(exp_mag[ch])}) begin
                errors++;
                $display("FAIL %s signmag ch%0d: got %h expected %h", name, ch,
                         result_out0[ch*RES_W +: RES_W], {exp_sgn[ch], MAG_W'(exp_mag[ch])});
            end
        end
        checks++;
        if (sum_out !== SUM_W'(exp_sum) || sum_out0 !== SUM_W'(exp_sum)) begin
            errors++;
            $display("FAIL %s sum: got %h/%h expected %h", name, sum_out, sum_out0, SUM_W'(exp_sum));
        end
        checks++;
        if (bubble_err !== exp_bub || bubble_err0 !== exp_bub) begin
            errors++;
            $display("FAIL %s bubble: got %b/%b expected %b", name, bubble_err, bubble_err0, exp_bub);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL %s ctrl: got valid=%b busy=%b expected 0", name, out_valid, busy);
        end
        checks++;
        if (result_out !== '0 || result_out0 !== '0 || mag_out !== '0 || mag_out0 !== '0) begin
            errors++;
            $display("FAIL %s data: got result=%h mag=%h expected 0", name, result_out, mag_out);
        end
        checks++;
        if (sum_out !== '0 || sum_out0 !== '0 || bubble_err !== '0 || bubble_err0 !== '0) begin
            errors++;
            $display("FAIL %s sum/bubble: got %h/%b expected 0", name, sum_out, bubble_err);
        end
    endtask

    task automatic check_ctrl(input string name, input logic exp_busy, input logic exp_valid);
        checks++;
        if (busy !== exp_busy || out_valid !== exp_valid ||
            busy0 !== exp_busy || out_valid0 !== exp_valid) begin
            errors++;
            $display("FAIL %s ctrl: got busy=%b valid=%b expected busy=%b valid=%b",
                     name, busy, out_valid, exp_busy, exp_valid);
        end
    endtask

    task automatic sign_beat(input string name);
        start = 1'b1; serial_valid = 1'b1; serial_in = cur_sign;
        @(posedge clk); #1;
        start = 1'b0; serial_valid = 1'b0; serial_in = N'($urandom);
        check_ctrl({name, "_sign"}, 1'b1, 1'b0);
    endtask

    // Magnitude beats with nstall idle cycles scattered strictly inside the frame.
    task automatic drive_beats(input int nstall, input string name);
        int left = nstall;
        for (int k = 0; k < L; k++) begin
            while (left > 0 && k > 0 && ($urandom_range(0, 3) == 0 || left >= L - k)) begin
                serial_valid = 1'b0; serial_in = N'($urandom); start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                left--;
                check_ctrl({name, "_stall"}, 1'b1, 1'b0);
            end
            serial_valid = 1'b1; serial_in = beat_bits[k]; start = 1'($urandom_range(0, 1));
            if (k == L - 1) check_ctrl({name, "_early"}, 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        serial_valid = 1'b0; start = 1'b0;
        check_ctrl({name, "_latency"}, 1'b0, 1'b1);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_ctrl({name, "_accept"}, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input int nstall, input string name);
        compute_expected();
        sign_beat(name);
        drive_beats(nstall, name);
        check_outputs(name);
        handshake(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; serial_valid = 1'b0; serial_in = '0;
        abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        cur_sign = '0;
        set_therm(0, 5); set_therm(1, 0); set_therm(2, 32); set_therm(3, 17);
        run_frame(0, "basic");
    endtask

    task automatic test_negative();
        cur_sign = '1;
        set_therm(0, 3); set_therm(1, 0); set_therm(2, 32); set_therm(3, 1);
        run_frame(0, "negative");
    endtask

    task automatic test_bubble();
        gen_frame(1'b1);
        for (int k = 0; k < L; k++) beat_bits[k][2] = (k == 0 || k == 1 || k == 3);
        run_frame(0, "bubble");
    endtask

    task automatic test_stall();
        gen_frame(1'b0);
        run_frame(7, "stall");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            gen_frame(1'($urandom_range(0, 1)));
            run_frame($urandom_range(0, 5), "random");
        end
    endtask

    task automatic test_back_to_back();
        gen_frame(1'b1);
        compute_expected();
        sign_beat("hold");
        drive_beats(0, "hold");
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0;
            start = 1'($urandom_range(0, 1)); serial_valid = 1'($urandom_range(0, 1));
            serial_in = N'($urandom);
            @(posedge clk); #1;
            check_ctrl("hold_wait", 1'b0, 1'b1);
            check_outputs("hold_stable");
        end
        gen_frame(1'b0);
        out_ready = 1'b1; start = 1'b1; serial_valid = 1'b1; serial_in = cur_sign;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0; serial_valid = 1'b0;
        check_ctrl("b2b_sign", 1'b1, 1'b0);
        compute_expected();
        drive_beats(0, "b2b");
        check_outputs("b2b");
        handshake("b2b");
    endtask

    task automatic test_abort_reset();
        gen_frame(1'b0);
        compute_expected();
        sign_beat("abort_hold");
        drive_beats(0, "abort_hold");
        abort = 1'b1; start = 1'b1; serial_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; serial_valid = 1'b0;
        check_ctrl("abort_hold", 1'b0, 1'b0);
        check_outputs("abort_hold_keep");
        // New frame cancelled on its 10th magnitude beat.
        start = 1'b1; serial_valid = 1'b1; serial_in = N'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            serial_in = N'($urandom);
            abort = (k == 10);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        check_ctrl("abort_shift", 1'b0, 1'b0);
        check_outputs("abort_shift_keep");
        @(posedge clk); #1;
        serial_valid = 1'b0;
        check_ctrl("abort_idle", 1'b0, 1'b0);
        // New frame interrupted by reset after its 20th beat.
        gen_frame(1'b0);
        sign_beat("rst_mid");
        for (int k = 0; k < 20; k++) begin
            serial_valid = 1'b1; serial_in = beat_bits[k];
            @(posedge clk); #1;
        end
        serial_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        gen_frame(1'b0);
        run_frame(3, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_bubble();
        test_stall();
        test_random();
        test_back_to_back();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/therm_serial_to_2scomp_multi.md
# therm_serial_to_2scomp_multi

Parametrised, multi-channel successor to the single-channel serial thermometer-to-binary converter in the partial product adder path. NUM_CH serial thermometer streams are received in lock-step, each framed as one sign beat followed by THERM_LEN magnitude beats. Each channel is converted to a true two's-complement value, or to legacy sign-magnitude in mode 0. The block also produces the signed sum across all channels, flags non-thermometer (bubble) sequences, and holds its result under a valid/ready handshake.

## Interface
- THERM_LEN, 32: magnitude beats per frame, excluding the sign beat; must be ≥ 1.
- NUM_CH, 4: number of parallel serial channels; must be ≥ 1.
- OUT_MODE, 1: 1 = two's complement per channel, 0 = sign-magnitude {sign, mag}.
- Derived: MAG_W = $clog2(THERM_LEN+1); RES_W = MAG_W+1; SUM_W = RES_W+$clog2(NUM_CH) (+1 when NUM_CH=1 is not required).

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start; the beat it qualifies is the sign beat.
- serial_valid  in  1  qualifies serial_in for the current cycle.
- serial_in  in  NUM_CH  one bit per channel; bit i belongs to channel i.
- abort  in  1  synchronous frame cancel.
- busy  out  1  high in SHIFT.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accept.
- result_out  out  NUM_CH*RES_W  per-channel result; channel i occupies [i*RES_W +: RES_W].
- mag_out  out  NUM_CH*MAG_W  per-channel count of ones.
- sum_out  out  SUM_W  signed two's-complement sum of all channel values, independent of OUT_MODE.
- bubble_err  out  NUM_CH  channel saw a 1 after a 0 within its magnitude beats.

## Operation
The state machine has three states: IDLE, SHIFT and HOLD.

- **IDLE**
  - A beat is accepted when start && serial_valid.
  - On acceptance, latch sign[i] = serial_in[i], clear magnitudes, beat counter and bubble state, then go to SHIFT.
  - start without serial_valid is ignored.
- **SHIFT**
  - Each cycle with serial_valid is one magnitude beat: mag[i] += serial_in[i] and beat_cnt++.
  - Cycles without serial_valid stall; no state changes.
  - start is ignored in SHIFT.
  - Bubble detection: a channel that has seen a 0 beat and then receives a 1 sets bubble[i], sticky for the frame. The 1 is still counted.
  - When the THERM_LEN-th magnitude beat is accepted, go to HOLD and register all outputs.
- **HOLD**
  - out_valid=1 and outputs are stable until out_valid && out_ready.
  - On handshake with no accepted start beat, go to IDLE.
  - On handshake in the same cycle as start && serial_valid, that beat is the next frame's sign beat and the block goes directly to SHIFT (back-to-back frames).
  - start without a handshake is ignored.
- **Arithmetic**
  - Per-channel signed value v[i] = sign ? -mag : +mag, at RES_W bits.
  - A sign of 1 with mag 0 gives v = 0 (negative zero folds to zero).
  - OUT_MODE=0 drives result_out = {sign, mag} unchanged. sum_out always uses v[i].
  - mag = THERM_LEN (all ones) must not overflow MAG_W.
- **abort**
  - From any state, the next state is IDLE and out_valid drops the next cycle; outputs retain their last values.
  - abort has priority over start and handshake.

## Timing
- Reset values: out_valid=0, busy=0, result_out=0, mag_out=0, sum_out=0, bubble_err=0. The state machine resets to IDLE.
- Reset mid-frame discards the frame immediately and asynchronously.
- Latency: the last magnitude beat is accepted at cycle N; out_valid=1 at N+1 with all outputs valid.
- A frame with no stalls runs from the sign beat at T0 to out_valid at T0+THERM_LEN+1.
- Minimum frame period is THERM_LEN+1 cycles with out_ready tied high.
- busy is high from the cycle after the sign beat until the cycle after the last beat.

## Structure
- Package therm2sc_pkg holds:
  - the state enum {IDLE, SHIFT, HOLD};
  - width helper functions for MAG_W, RES_W and SUM_W.
- Sub-module therm_channel_counter, instantiated NUM_CH times, holds:
  - sign latch;
  - magnitude counter;
  - bubble tracking;
  - signed-value output.
- The top level holds the state machine, beat counter, adder tree for sum_out and output registers.

## Test plan
- THERM_LEN=32, NUM_CH=4, each channel sends sign 0 with 5/0/32/17 ones → mag 5/0/32/17, result 5/0/32/17, sum 54, bubble_err 0, out_valid at T0+33.
- Channels sign 1 with mags 3/0/32/1, OUT_MODE=1 → results -3/0/-32/-1 (channel 1 gives 0, not negative zero), sum -36. The same stimulus with OUT_MODE=0 gives result {1,mag} and the same sum.
- Channel 2 pattern 1,1,0,1,0… → bubble_err=4'b0100, mag 3.
- serial_valid low for 7 random cycles mid-frame → identical results, out_valid at T0+40.
- out_ready low for 10 cycles → outputs stable. Then handshake plus start on the same cycle → the second frame completes at +33 with no lost beat.
- abort at beat 10, then rst at beat 20 of a new frame → IDLE, all outputs return to reset values, and the next frame converts correctly.
